ir_key_event: RTL
=================

Name: ir_key_event

Overview:
- Sits directly downstream of the NEC IR decoder (remote_rcv).
- Converts its raw outputs (data_en frame pulse, data code, repeat_en repeat pulse) into clean key events: DOWN, autorepeat RPT and timeout-derived UP.
- Queues events in a small FIFO with a valid/ready interface, so display or control logic (LCD text, LED, menus) can consume presses without missing any.
- Also exposes a live key-held level and the current code.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- RELEASE_MS, 150: silence in ms (no frame, no repeat) after which a held key is released. Must exceed the NEC repeat period of 108 ms.
- RPT_DELAY, 4: number of repeat frames before the first RPT event.
- RPT_DIV, 2: after RPT_DELAY is reached, emit one RPT every RPT_DIV repeat frames.
- FIFO_DEPTH, 8: event queue depth, power of two, ≥2.

Ports:
- sys_clk, in, 1: single clock.
- sys_rst, in, 1: reset, synchronous, active-high.
- data_en, in, 1: one-cycle pulse; a new valid frame was decoded.
- data, in, 8: command code; valid when data_en=1.
- repeat_en, in, 1: one-cycle pulse per NEC repeat frame.
- ev_valid, out, 1: FIFO not empty.
- ev_ready, in, 1: consumer pops the head when ev_valid&&ev_ready.
- ev_data, out, 10: head event. [9:8] type (01 DOWN, 10 UP, 11 RPT); [7:0] code.
- key_held, out, 1: level; a key is currently pressed.
- key_code, out, 8: last captured code; holds its value after release.
- ovf, out, 1: sticky; an event was dropped because the FIFO was full.
- ovf_clr, in, 1: clears ovf.

Behaviour:
- Reset (sys_clk edge with sys_rst=1) sets:
  - state IDLE, FIFO empty, ev_valid=0, ev_data=0;
  - key_held=0, key_code=0, ovf=0;
  - all counters 0.
  - Reset mid-hold discards the hold and emits no UP.
- Release timer:
  - TMO = CLK_FREQ/1000*RELEASE_MS cycles; width clog2(TMO+1).
  - Reloads to 0 on data_en or repeat_en while HELD.
  - Counts +1 per cycle in HELD; timeout fires when the count reaches TMO-1.
- States:
  - IDLE:
    - data_en: key_code<=data, push DOWN, go HELD, timer=0, rep_cnt=0.
    - repeat_en: ignored (orphan repeat).
  - HELD:
    - repeat_en: rep_cnt saturating increment (width clog2(RPT_DELAY+RPT_DIV)+1).
    - RPT is pushed when rep_cnt_new==RPT_DELAY, and thereafter every RPT_DIV repeats via a div counter that wraps at RPT_DIV-1.
    - RPT events carry key_code.
    - Timeout with no data_en: push UP(key_code), go IDLE.
    - data_en (any code, including the same code, since a new frame means a new press): push UP(old key_code), latch new code into a pending reg, go PEND.
    - data_en together with timeout in the same cycle: treated as data_en.
  - PEND (exactly one cycle): push DOWN(pending code), key_code<=pending, go HELD, timer=0, rep_cnt=0. data_en/repeat_en during PEND are ignored.
- key_held is 1 in HELD and PEND.
- At most one push per cycle.
- FIFO:
  - Registered; a push is visible on ev_valid the next cycle, so DOWN appears 1 cycle after data_en.
  - Read and write in the same cycle are both performed.
  - Full without a simultaneous pop: the push is dropped and ovf<=1.
  - Full with a simultaneous pop: the push is accepted.
  - Empty with ev_ready=1: no effect.
  - ovf_clr and a new overflow in the same cycle: ovf stays 1.
  - Pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
- ev_data is driven from the FIFO head and equals 0 when empty.

Decomposition:
- Package ir_pkg holds:
  - the event-type localparams EV_DOWN=2'b01, EV_UP=2'b10, EV_RPT=2'b11;
  - the event width EV_W=10;
  - state encodings IDLE/HELD/PEND.
- One sub-module, ir_evt_fifo: a parameterised synchronous FIFO (width EV_W, depth FIFO_DEPTH) with push/pop/full/empty.
- The FSM, timer and repeat counters stay in ir_key_event.

Test Plan:
- Bench parameters: CLK_FREQ=1000, RELEASE_MS=10 (TMO=10), RPT_DELAY=2, RPT_DIV=2, FIFO_DEPTH=4.
- Single press: data_en with data=0x45, ev_ready=1, then silence.
  - ev_data=0x145 (DOWN) one cycle later; key_held=1.
  - 10 cycles later, UP 0x245 is pushed; key_held=0; key_code stays 0x45.
- Autorepeat: press 0x16, then 5 repeat_en pulses spaced 5 cycles apart.
  - RPT 0x316 after the 2nd and 4th repeats only.
  - UP 0x216 10 cycles after the last repeat.
- Key change: while 0x45 is held, data_en with 0x09.
  - Consecutive events UP 0x245, then DOWN 0x109 on the next cycle.
  - Same-code re-press 0x09 gives UP 0x209, then DOWN 0x109.
- Overflow: ev_ready=0; DOWN 0x01, then re-presses generating 6 events.
  - FIFO holds the first 4 events; ovf=1.
  - ovf_clr clears ovf; draining returns the 4 events in order.
- Edge cases:
  - repeat_en in IDLE: no event.
  - data_en on the exact timeout cycle: UP then DOWN, no double UP.
  - sys_rst asserted while HELD with 2 queued events: ev_valid=0 and key_held=0 on the next cycle, no UP emitted.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared event encoding and FSM states for the IR key-event block.
package ir_pkg;

  localparam int EV_W = 10;

  localparam logic [1:0] EV_DOWN = 2'b01;
  localparam logic [1:0] EV_UP   = 2'b10;
  localparam logic [1:0] EV_RPT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    PEND = 2'd2
  } state_t;

  function automatic logic [EV_W-1:0] mk_ev(input logic [1:0] typ, input logic [7:0] code);
    return {typ, code};
  endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Registered sync FIFO: a push shows on the head one cycle later; head reads 0 when empty.
// A push while full is dropped unless a pop happens in the same cycle.
module ir_evt_fifo
  import ir_pkg::*;
#(
  parameter int W     = EV_W,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/ir_key_event.sv
// Turns NEC decoder pulses into queued DOWN/RPT/UP key events; DOWN is visible 1 cycle after data_en.
// Consumer pops with ev_valid&&ev_ready; pushes into a full queue are dropped and flagged on sticky ovf.
module ir_key_event
  import ir_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int RELEASE_MS = 150,
  parameter int RPT_DELAY  = 4,
  parameter int RPT_DIV    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            data_en,
  input  logic [7:0]      data,
  input  logic            repeat_en,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EV_W-1:0] ev_data,
  output logic            key_held,
  output logic [7:0]      key_code,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int TMO   = CLK_FREQ / 1000 * RELEASE_MS;
  localparam int TMR_W = $clog2(TMO + 1);
  localparam int REP_W = $clog2(RPT_DELAY + RPT_DIV) + 1;
  localparam int DIV_W = (RPT_DIV > 1) ? $clog2(RPT_DIV) : 1;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO - 1);
  localparam logic [REP_W-1:0] REP_SAT  = REP_W'(RPT_DELAY);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RPT_DIV - 1);

  state_t            r_state,     w_state_nxt;
  logic [TMR_W-1:0]  r_timer,     w_timer_nxt;
  logic [REP_W-1:0]  r_rep,       w_rep_nxt;
  logic [DIV_W-1:0]  r_div,       w_div_nxt;
  logic [7:0]        r_key_code,  w_key_code_nxt;
  logic [7:0]        r_pend_code, w_pend_code_nxt;
  logic              r_ovf;
  logic [REP_W-1:0]  w_rep_inc;
  logic              w_push;
  logic [EV_W-1:0]   w_push_dat;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  assign w_rep_inc = r_rep + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_rep_nxt       = r_rep;
    w_div_nxt       = r_div;
    w_key_code_nxt  = r_key_code;
    w_pend_code_nxt = r_pend_code;
    w_push          = 1'b0;
    w_push_dat      = '0;
    case (r_state)
      IDLE: begin
        if (data_en) begin
          w_key_code_nxt = data;
          w_push         = 1'b1;
          w_push_dat     = mk_ev(EV_DOWN, data);
          w_state_nxt    = HELD;
          w_timer_nxt    = '0;
          w_rep_nxt      = '0;
          w_div_nxt      = '0;
        end
      end
      HELD: begin
        // A new frame wins over a coincident timeout: old key goes UP, new key pends.
        if (data_en) begin
          w_push          = 1'b1;
          w_push_dat      = mk_ev(EV_UP, r_key_code);
          w_pend_code_nxt = data;
          w_state_nxt     = PEND;
          w_timer_nxt     = '0;
        end else if (repeat_en) begin
          w_timer_nxt = '0;
          if (r_rep < REP_SAT) begin
            w_rep_nxt = w_rep_inc;
            if (w_rep_inc == REP_SAT) begin
              w_push     = 1'b1;
              w_push_dat = mk_ev(EV_RPT, r_key_code);
              w_div_nxt  = '0;
            end
          end else if (r_div == DIV_LAST) begin
            w_push     = 1'b1;
            w_push_dat = mk_ev(EV_RPT, r_key_code);
            w_div_nxt  = '0;
          end else begin
            w_div_nxt = r_div + 1'b1;
          end
        end else if (r_timer == TMO_LAST) begin
          w_push      = 1'b1;
          w_push_dat  = mk_ev(EV_UP, r_key_code);
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      PEND: begin
        w_push         = 1'b1;
        w_push_dat     = mk_ev(EV_DOWN, r_pend_code);
        w_key_code_nxt = r_pend_code;
        w_state_nxt    = HELD;
        w_timer_nxt    = '0;
        w_rep_nxt      = '0;
        w_div_nxt      = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_drop = w_push && w_full && !ev_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_rep       <= '0;
      r_div       <= '0;
      r_key_code  <= '0;
      r_pend_code <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_rep       <= w_rep_nxt;
      r_div       <= w_div_nxt;
      r_key_code  <= w_key_code_nxt;
      r_pend_code <= w_pend_code_nxt;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  ir_evt_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (sys_clk),
    .i_rst      (sys_rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (ev_ready),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (ev_data)
  );

  assign ev_valid = !w_empty;
  assign key_held = (r_state != IDLE);
  assign key_code = r_key_code;
  assign ovf      = r_ovf;

endmodule
